// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing and frame width.
// The default bit timing is also used by the LED panel driver.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 20;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit. The reset value is a parameter
// so that an idle-high line does not look like a start bit while reset releases.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so that both flops sample
  // their inputs from before the edge; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronises the line, rejects false starts, samples mid-bit,
// and emits one-cycle rx_dv or frame_err strobes per received frame.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_serial,
  output logic                      rx_dv,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  rx_state_t                 state, state_next;
  logic [CNT_W-1:0]          bit_cnt, bit_cnt_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic [UART_DATA_BITS-1:0] rx_byte_next;
  logic                      rx_dv_next, frame_err_next;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // NOTE: every output of this block is given a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    bit_idx_next   = bit_idx;
    shreg_next     = shreg;
    rx_byte_next   = rx_byte;
    rx_dv_next     = 1'b0;
    frame_err_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next   = START;
          bit_cnt_next = '0;
        end
      end

      START: begin
        if (bit_cnt == HALF_LAST) begin
          bit_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          shreg_next[bit_idx] = rx_s;
          bit_cnt_next        = '0;
          bit_idx_next        = bit_idx + 3'd1;
          if (bit_idx == IDX_LAST) state_next = STOP;
        end else begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_next = '0;
          if (rx_s) begin
            rx_byte_next = shreg;
            rx_dv_next   = 1'b1;
            state_next   = CLEANUP;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
        end
      end

      // One dead cycle so the tail of the stop bit cannot re-arm the detector.
      CLEANUP: state_next = IDLE;

      // A held-low line reports one framing error, then waits for the line to recover.
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      shreg     <= shreg_next;
      rx_byte   <= rx_byte_next;
      rx_dv     <= rx_dv_next;
      frame_err <= frame_err_next;
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: drives 8N1 frames on the serial line and
// compares the observed strobes against frame-level expectations.
module tb_uart_byte_rx;

  localparam int C       = 20;
  localparam int LAT_MIN = 192;
  localparam int LAT_MAX = 193;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] dv_q[$];
  int         dv_t[$];
  int         fe_t[$];
  logic       rst_d = 1'b1;
  logic [7:0] prev_byte;
  logic       overlap_seen = 1'b0;
  logic       stray_change = 1'b0;
  logic [7:0] last_good;

  uart_byte_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_serial (rx_serial),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  // Event log, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rx_dv) begin
      dv_q.push_back(rx_byte);
      dv_t.push_back(cyc);
    end
    if (frame_err) fe_t.push_back(cyc);
    if (rx_dv && frame_err) overlap_seen = 1'b1;
    if (!rst_d && !rx_dv && rx_byte !== prev_byte) stray_change = 1'b1;
    prev_byte = rx_byte;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    dv_q.delete();
    dv_t.delete();
    fe_t.delete();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, output int t0);
    t0 = cyc;
    rx_serial = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx_serial = data[i];
      tick(C);
    end
    rx_serial = stop;
    tick(C);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_serial = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    n_checks++; if (rx_dv !== 1'b0) $display("FAIL reset_rx_dv: got %b want 0", rx_dv); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte: got %h want 00", rx_byte); else n_pass++;
    last_good = 8'h00;
    tick(5);
  endtask

  task automatic test_single();
    int t0;
    int lat;
    logic [7:0] got;
    clear_log();
    send_frame(8'h35, 1'b1, t0);
    tick(10);
    got = (dv_q.size() > 0) ? dv_q[0] : 8'hxx;
    lat = (dv_t.size() > 0) ? dv_t[0] - t0 : -1;
    n_checks++; if (dv_q.size() != 1) $display("FAIL single_dv_count: got %0d want 1", dv_q.size()); else n_pass++;
    n_checks++; if (got !== 8'h35) $display("FAIL single_byte: got %h want 35", got); else n_pass++;
    n_checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); else n_pass++;
    n_checks++; if (fe_t.size() != 0) $display("FAIL single_frame_err: got %0d pulses want 0", fe_t.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b want 0", busy); else n_pass++;
    last_good = 8'h35;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    int t0;
    logic [7:0] got;
    int gap;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h12;
    clear_log();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, t0);
    tick(10);
    n_checks++; if (dv_q.size() != 3) $display("FAIL b2b_dv_count: got %0d want 3", dv_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      got = (dv_q.size() > i) ? dv_q[i] : 8'hxx;
      n_checks++; if (got !== bytes[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, got, bytes[i]); else n_pass++;
    end
    for (int i = 1; i < 3; i++) begin
      gap = (dv_t.size() > i) ? dv_t[i] - dv_t[i-1] : -1;
      n_checks++; if (gap != 10 * C) $display("FAIL b2b_spacing%0d: got %0d want %0d", i, gap, 10 * C); else n_pass++;
    end
    n_checks++; if (fe_t.size() != 0) $display("FAIL b2b_frame_err: got %0d pulses want 0", fe_t.size()); else n_pass++;
    last_good = 8'h12;
  endtask

  task automatic test_glitch();
    int busy_cycles = 0;
    clear_log();
    for (int i = 0; i < 45; i++) begin
      rx_serial = (i < 5) ? 1'b0 : 1'b1;
      tick(1);
      if (busy) busy_cycles++;
    end
    n_checks++; if (dv_q.size() != 0) $display("FAIL glitch_dv: got %0d pulses want 0", dv_q.size()); else n_pass++;
    n_checks++; if (fe_t.size() != 0) $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_t.size()); else n_pass++;
    // Half a bit of START, counted either exclusive or inclusive of the validation edge.
    n_checks++; if (busy_cycles < C / 2 || busy_cycles > C / 2 + 1)
      $display("FAIL glitch_busy_cycles: got %0d want %0d..%0d", busy_cycles, C / 2, C / 2 + 1); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_frame_err();
    int t0;
    logic [7:0] got;
    clear_log();
    send_frame(8'hA5, 1'b0, t0);
    tick(100);
    rx_serial = 1'b1;
    tick(10);
    n_checks++; if (fe_t.size() != 1) $display("FAIL ferr_count: got %0d want 1", fe_t.size()); else n_pass++;
    n_checks++; if (dv_q.size() != 0) $display("FAIL ferr_dv: got %0d pulses want 0", dv_q.size()); else n_pass++;
    n_checks++; if (rx_byte !== last_good) $display("FAIL ferr_byte_kept: got %h want %h", rx_byte, last_good); else n_pass++;
    clear_log();
    send_frame(8'h3C, 1'b1, t0);
    tick(10);
    got = (dv_q.size() > 0) ? dv_q[0] : 8'hxx;
    n_checks++; if (got !== 8'h3C || dv_q.size() != 1) $display("FAIL ferr_recover: got %h x%0d want 3c x1", got, dv_q.size()); else n_pass++;
    last_good = 8'h3C;
  endtask

  task automatic test_reset_mid();
    logic [7:0] data = 8'h55;
    int t0;
    logic [7:0] got;
    clear_log();
    rx_serial = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx_serial = data[i];
      tick(C);
    end
    rx_serial = data[4];
    tick(C / 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rx_serial = 1'b1;
    n_checks++; if (rx_dv !== 1'b0 || frame_err !== 1'b0) $display("FAIL midrst_strobes: got dv=%b fe=%b want 0 0", rx_dv, frame_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rx_byte !== 8'h00) $display("FAIL midrst_byte: got %h want 00", rx_byte); else n_pass++;
    tick(300);
    n_checks++; if (dv_q.size() != 0 || fe_t.size() != 0) $display("FAIL midrst_no_strobe: got dv=%0d fe=%0d want 0 0", dv_q.size(), fe_t.size()); else n_pass++;
    send_frame(8'h20, 1'b1, t0);
    tick(10);
    got = (dv_q.size() > 0) ? dv_q[0] : 8'hxx;
    n_checks++; if (got !== 8'h20 || dv_q.size() != 1) $display("FAIL midrst_next_byte: got %h x%0d want 20 x1", got, dv_q.size()); else n_pass++;
    last_good = 8'h20;
  endtask

  task automatic test_break();
    clear_log();
    rx_serial = 1'b0;
    tick(2000);
    n_checks++; if (busy !== 1'b1) $display("FAIL break_busy_held: got %b want 1", busy); else n_pass++;
    n_checks++; if (fe_t.size() != 1) $display("FAIL break_fe_count: got %0d want 1", fe_t.size()); else n_pass++;
    n_checks++; if (dv_q.size() != 0) $display("FAIL break_dv: got %0d pulses want 0", dv_q.size()); else n_pass++;
    rx_serial = 1'b1;
    tick(6);
    n_checks++; if (busy !== 1'b0) $display("FAIL break_busy_release: got %b want 0", busy); else n_pass++;
    n_checks++; if (rx_byte !== last_good) $display("FAIL break_byte_kept: got %h want %h", rx_byte, last_good); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         t0_q[$];
    int         t0;
    logic [7:0] b;
    logic [7:0] got;
    int         lat;
    clear_log();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, t0);
      t0_q.push_back(t0);
      tick($urandom_range(0, 30));
    end
    tick(10);
    n_checks++; if (dv_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", dv_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (dv_q.size() > i) ? dv_q[i] : 8'hxx;
      lat = (dv_t.size() > i) ? dv_t[i] - t0_q[i] : -1;
      n_checks++; if (got !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
      n_checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL rand_latency%0d: got %0d want %0d..%0d", i, lat, LAT_MIN, LAT_MAX); else n_pass++;
    end
    n_checks++; if (fe_t.size() != 0) $display("FAIL rand_frame_err: got %0d pulses want 0", fe_t.size()); else n_pass++;
  endtask

  task automatic test_invariants();
    n_checks++; if (overlap_seen !== 1'b0) $display("FAIL inv_dv_fe_overlap: got %b want 0", overlap_seen); else n_pass++;
    n_checks++; if (stray_change !== 1'b0) $display("FAIL inv_byte_stable: got %b want 0", stray_change); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_break();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- 8N1 UART receiver that turns the serial command line into byte strobes.
- Sits directly upstream of the LED panel driver; its rx_dv/rx_byte pair feeds the panel's command decoder (colour, set/clear pixel, clear screen).
- Adds input synchronisation, false-start rejection and framing-error detection, so a noisy line never writes the frame buffer.

Parameters:
- CLKS_PER_BIT, 20: clk cycles per serial bit; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer divide): cycles from the detected falling edge to the start-bit validation sample.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line; idle high.
- rx_dv  out  1  one-cycle strobe: rx_byte holds a new valid byte.
- rx_byte  out  8  last good byte; LSB received first.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: rx_dv=0, frame_err=0, busy=0, rx_byte=8'h00, FSM=IDLE, counters=0, both synchroniser flops=1.
- Reset wins over every other event, including mid-byte. No strobe is produced for a byte interrupted by reset.
- Synchroniser: 2-FF chain on rx_serial produces rx_s, which is 2 cycles late. All FSM decisions use rx_s only.
- bit_cnt is clog2(CLKS_PER_BIT) bits wide; bit_idx is 3 bits.
- IDLE:
  - rx_s==0 at edge c0 -> START, bit_cnt=0.
  - Otherwise stay in IDLE.
- START:
  - Increment bit_cnt until bit_cnt==HALF_BIT-1; that edge is c0+HALF_BIT.
  - At that edge: rx_s==0 -> DATA, bit_cnt=0, bit_idx=0.
  - rx_s==1 -> IDLE (glitch rejected; no strobe).
- DATA:
  - At bit_cnt==CLKS_PER_BIT-1: shift rx_s into shift-register bit bit_idx, reset bit_cnt, increment bit_idx.
  - Bit i is sampled at c0+HALF_BIT+(i+1)*CLKS_PER_BIT.
  - After bit 7 -> STOP, bit_cnt=0.
- STOP: at bit_cnt==CLKS_PER_BIT-1, i.e. edge c0+HALF_BIT+9*CLKS_PER_BIT:
  - rx_s==1 -> rx_byte<=shift register, rx_dv<=1 for exactly one cycle, go to CLEANUP.
  - rx_s==0 -> frame_err<=1 for one cycle, rx_byte unchanged, go to BREAK.
- CLEANUP: one cycle, then IDLE. Prevents re-triggering on the stop-bit edge.
- BREAK: hold until rx_s==1, then IDLE. A held-low line (break) yields exactly one frame_err and no further activity.
- Latency: rx_dv is high in the cycle after edge c0+HALF_BIT+9*CLKS_PER_BIT; c0 is 2-3 cycles after the rx_serial falling edge. For CLKS_PER_BIT=20 that is 190 cycles after c0.
- Back-to-back bytes: a start bit beginning immediately after a full stop bit is accepted. CLEANUP costs 1 cycle, which is within the HALF_BIT margin.
- rx_dv and frame_err are never high in the same cycle. rx_byte changes only in the rx_dv cycle.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t: IDLE, START, DATA, STOP, CLEANUP, BREAK.
  - Default CLKS_PER_BIT=20, shared with the panel driver.
  - UART_DATA_BITS=8.
- One sub-module: sync_2ff (1-bit two-flop synchroniser, reset value parameterised, here 1).

Test Plan (CLKS_PER_BIT=20, 20 clk per bit, line idle high):
- Send 0x35 8N1 -> one rx_dv pulse 190 cycles after c0, rx_byte=0x35, frame_err stays 0, busy returns to 0.
- Send 0x00, 0xFF, 0x12 back-to-back with no idle gap -> three rx_dv pulses 200 cycles apart, bytes in order, no frame_err.
- 5-cycle low glitch on idle line -> no rx_dv, no frame_err, busy high for 11 cycles (START through HALF_BIT), then IDLE.
- Send 0xA5 with stop bit forced low, line held low 100 more cycles -> one frame_err pulse, no rx_dv, rx_byte keeps previous value; after the line goes high, a following 0x3C is received correctly.
- Assert reset for 1 cycle during data bit 4 of 0x55 -> all outputs at reset values, no strobe. The next full byte 0x20 is received correctly.
- Hold rx_serial low 2000 cycles (break) -> exactly one frame_err, busy high until the line returns high, then IDLE.
